vnp4_stream_sink: RTL and testbench



---
 rtl/vnp4_sink_pkg.sv | 34 +++
 rtl/axi_stream_vnp4_if.sv | 33 +++
 rtl/vnp4_keep_decode.sv | 34 +++
 rtl/vnp4_stream_sink.sv | 196 +++++++++++++++++++
 tb/tb_vnp4_stream_sink.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vnp4_sink_pkg.sv
// ----------------------------------------------------------------------------
// vnp4_sink_pkg : shared widths, error bit indices and types for the VNP4 sink
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vnp4_sink_pkg;

  localparam int KEEP_W = 64;
  localparam int DATA_W = 512;
  localparam int PORT_W = 9;
  localparam int SIZE_W = 16;
  localparam int BEAT_BYTES_W = 7;
  localparam int ERR_W = 4;

  localparam int ERR_KEEP  = 0;
  localparam int ERR_SIZE  = 1;
  localparam int ERR_META  = 2;
  localparam int ERR_EMPTY = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

  typedef struct packed {
    logic [SIZE_W-1:0] size;
    logic [PORT_W-1:0] ingress;
    logic [PORT_W-1:0] egress;
  } pkt_info_t;

endpackage

`default_nettype wire

// File: rtl/axi_stream_vnp4_if.sv
// ----------------------------------------------------------------------------
// axi_stream_vnp4_if : 512-bit VNP4 AXI-stream bundle with sideband user fields
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface axi_stream_vnp4_if;
  import vnp4_sink_pkg::*;

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [KEEP_W-1:0] keep;
  logic              last;
  logic              user_valid;
  logic [SIZE_W-1:0] user_size;
  logic [PORT_W-1:0] user_ingress_port;
  logic [PORT_W-1:0] user_egress_port;

  modport slave (
    input  valid, data, keep, last, user_valid, user_size,
           user_ingress_port, user_egress_port,
    output ready
  );

  modport master (
    output valid, data, keep, last, user_valid, user_size,
           user_ingress_port, user_egress_port,
    input  ready
  );
endinterface

`default_nettype wire

// File: rtl/vnp4_keep_decode.sv
// ----------------------------------------------------------------------------
// vnp4_keep_decode : byte count of a keep mask plus full / low-contiguous flags
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vnp4_keep_decode
  import vnp4_sink_pkg::*;
(
  input  logic [KEEP_W-1:0]       keep,
  output logic [BEAT_BYTES_W-1:0] bytes,
  output logic                    full,
  output logic                    contig
);

  localparam logic [KEEP_W-1:0] KEEP_ONE = {{(KEEP_W-1){1'b0}}, 1'b1};

  logic [KEEP_W-1:0] keep_inc;

  always_comb begin
    bytes = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      bytes = bytes + {{(BEAT_BYTES_W-1){1'b0}}, keep[i]};
    end
  end

  // A mask filled from bit 0 has the form 2^n-1, so adding one clears every set bit.
  assign keep_inc = keep + KEEP_ONE;
  assign contig   = ((keep & keep_inc) == '0);
  assign full     = &keep;

endmodule

`default_nettype wire

// File: rtl/vnp4_stream_sink.sv
// ----------------------------------------------------------------------------
// vnp4_stream_sink : VNP4 stream terminator with packet/byte/error statistics.
// Optional LFSR backpressure when VNP4_SINK_BACKPRESSURE_EN is defined.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vnp4_stream_sink
  import vnp4_sink_pkg::*;
#(
  parameter int unsigned PKT_CNT_W  = 32,
  parameter int unsigned BYTE_CNT_W = 48,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2B37
) (
  input  logic                  aclk,
  input  logic                  areset,
  axi_stream_vnp4_if.slave      s_axis,
  input  logic                  stats_clr,
`ifdef VNP4_SINK_BACKPRESSURE_EN
  input  logic                  throttle_dis,
`endif
  output logic                  pkt_done,
  output logic [SIZE_W-1:0]     last_size,
  output logic [PORT_W-1:0]     last_ingress,
  output logic [PORT_W-1:0]     last_egress,
  output logic [PKT_CNT_W-1:0]  pkt_count,
  output logic [BYTE_CNT_W-1:0] byte_count,
  output logic [PKT_CNT_W-1:0]  err_count,
  output logic [ERR_W-1:0]      err_flags
);

  localparam logic [PKT_CNT_W-1:0] PKT_ONE = {{(PKT_CNT_W-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [SIZE_W-1:0]       acc_q, acc_d;
  logic [ERR_W-1:0]        perr_q, perr_d;
  logic                    run_q, run_d;
  logic                    pkt_done_q, pkt_done_d;
  pkt_info_t               last_q, last_d;
  logic [PKT_CNT_W-1:0]    pkt_count_q, pkt_count_d;
  logic [PKT_CNT_W-1:0]    err_count_q, err_count_d;
  logic [BYTE_CNT_W-1:0]   byte_count_q, byte_count_d;
  logic [ERR_W-1:0]        err_flags_q, err_flags_d;

  logic                    ready;
  logic                    accept;
  logic [BEAT_BYTES_W-1:0] beat_bytes;
  logic                    beat_full;
  logic                    beat_contig;
  logic [SIZE_W-1:0]       acc_base;
  logic [ERR_W-1:0]        perr_base;
  logic [SIZE_W:0]         sum;
  logic [SIZE_W-1:0]       total;
  logic [ERR_W-1:0]        beat_err;
  logic [ERR_W-1:0]        pkt_err;
  logic                    unused_data;

  vnp4_keep_decode u_keep_decode (
    .keep   (s_axis.keep),
    .bytes  (beat_bytes),
    .full   (beat_full),
    .contig (beat_contig)
  );

  assign unused_data = ^s_axis.data;

`ifdef VNP4_SINK_BACKPRESSURE_EN
  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign ready = run_q & (throttle_dis | lfsr_q[0] | lfsr_q[1]);
`else
  logic [31:0] unused_lfsr_seed;
  assign unused_lfsr_seed = LFSR_SEED;
  assign ready            = run_q;
`endif

  assign s_axis.ready = ready;
  assign accept       = s_axis.valid & ready;

  // Per-beat byte accumulation and error classification.
  always_comb begin
    acc_base  = '0;
    perr_base = '0;
    case (state_q)
      BODY: begin
        acc_base  = acc_q;
        perr_base = perr_q;
      end
      default: ;
    endcase

    sum   = {1'b0, acc_base} + {{(SIZE_W+1-BEAT_BYTES_W){1'b0}}, beat_bytes};
    total = sum[SIZE_W] ? '1 : sum[SIZE_W-1:0];

    beat_err            = '0;
    beat_err[ERR_KEEP]  = s_axis.last ? ~beat_contig : ~beat_full;
    beat_err[ERR_EMPTY] = (beat_bytes == '0);
    beat_err[ERR_META]  = s_axis.last ^ s_axis.user_valid;
    beat_err[ERR_SIZE]  = sum[SIZE_W] |
                          (s_axis.last & s_axis.user_valid & (s_axis.user_size != total));
    pkt_err             = perr_base | beat_err;
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    perr_d       = perr_q;
    run_d        = 1'b1;
    pkt_done_d   = 1'b0;
    last_d       = last_q;
    pkt_count_d  = pkt_count_q;
    byte_count_d = byte_count_q;
    err_count_d  = err_count_q;
    err_flags_d  = err_flags_q;

    if (stats_clr) begin
      pkt_count_d  = '0;
      byte_count_d = '0;
      err_count_d  = '0;
      err_flags_d  = '0;
    end

    if (accept) begin
      if (s_axis.last) begin
        state_d        = IDLE;
        acc_d          = '0;
        perr_d         = '0;
        pkt_done_d     = 1'b1;
        last_d.size    = total;
        last_d.ingress = s_axis.user_ingress_port;
        last_d.egress  = s_axis.user_egress_port;
        // A simultaneous clear drops this packet from the statistics.
        if (!stats_clr) begin
          pkt_count_d  = pkt_count_q + PKT_ONE;
          byte_count_d = byte_count_q + {{(BYTE_CNT_W-SIZE_W){1'b0}}, total};
          err_count_d  = (|pkt_err) ? err_count_q + PKT_ONE : err_count_q;
          err_flags_d  = err_flags_q | pkt_err;
        end
      end else begin
        state_d = BODY;
        acc_d   = total;
        perr_d  = pkt_err;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      perr_q       <= '0;
      run_q        <= 1'b0;
      pkt_done_q   <= 1'b0;
      last_q       <= '0;
      pkt_count_q  <= '0;
      byte_count_q <= '0;
      err_count_q  <= '0;
      err_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      perr_q       <= perr_d;
      run_q        <= run_d;
      pkt_done_q   <= pkt_done_d;
      last_q       <= last_d;
      pkt_count_q  <= pkt_count_d;
      byte_count_q <= byte_count_d;
      err_count_q  <= err_count_d;
      err_flags_q  <= err_flags_d;
    end
  end

  assign pkt_done     = pkt_done_q;
  assign last_size    = last_q.size;
  assign last_ingress = last_q.ingress;
  assign last_egress  = last_q.egress;
  assign pkt_count    = pkt_count_q;
  assign byte_count   = byte_count_q;
  assign err_count    = err_count_q;
  assign err_flags    = err_flags_q;

endmodule

`default_nettype wire

// File: tb/tb_vnp4_stream_sink.sv
// ----------------------------------------------------------------------------
// tb_vnp4_stream_sink : table-driven + scoreboard bench for vnp4_stream_sink
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_vnp4_stream_sink;
  import vnp4_sink_pkg::*;

  localparam logic [63:0] F = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        stats_clr = 1'b0;
`ifdef VNP4_SINK_BACKPRESSURE_EN
  logic        throttle_dis = 1'b1;
`endif
  logic        pkt_done;
  logic [15:0] last_size;
  logic [8:0]  last_ingress;
  logic [8:0]  last_egress;
  logic [31:0] pkt_count;
  logic [47:0] byte_count;
  logic [31:0] err_count;
  logic [3:0]  err_flags;

  axi_stream_vnp4_if s_axis_if ();

  always #5 aclk = ~aclk;

  vnp4_stream_sink dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis       (s_axis_if),
    .stats_clr    (stats_clr),
`ifdef VNP4_SINK_BACKPRESSURE_EN
    .throttle_dis (throttle_dis),
`endif
    .pkt_done     (pkt_done),
    .last_size    (last_size),
    .last_ingress (last_ingress),
    .last_egress  (last_egress),
    .pkt_count    (pkt_count),
    .byte_count   (byte_count),
    .err_count    (err_count),
    .err_flags    (err_flags)
  );

  typedef struct {
    logic [63:0] keep;
    logic        last;
    logic        uv;
    logic [15:0] usize;
    logic [8:0]  ing;
    logic [8:0]  egr;
    logic        clr;
    logic [15:0] e_size;
    logic [63:0] e_pkt;
    logic [63:0] e_bytes;
    logic [63:0] e_errc;
    logic [3:0]  e_flags;
  } vec_t;

  typedef struct {
    logic [15:0] size;
    logic [8:0]  ing;
    logic [8:0]  egr;
    logic [63:0] pkt;
    logic [63:0] bytes;
    logic [63:0] errc;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb_q[$];
  vec_t vt[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   ready_low = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] keep, input logic last, input logic uv,
                              input logic [15:0] usize, input logic [8:0] ing, input logic [8:0] egr,
                              input logic clr, input logic [15:0] es, input logic [63:0] ep,
                              input logic [63:0] eb, input logic [63:0] ec, input logic [3:0] ef);
    vec_t v;
    v.keep = keep; v.last = last; v.uv = uv; v.usize = usize; v.ing = ing; v.egr = egr;
    v.clr = clr; v.e_size = es; v.e_pkt = ep; v.e_bytes = eb; v.e_errc = ec; v.e_flags = ef;
    return v;
  endfunction

  // Presents a beat at a negedge, holds it until accepted, returns at the following negedge.
  task automatic send_beat(input logic [63:0] keep, input logic last, input logic uv,
                           input logic [15:0] usize, input logic [8:0] ing, input logic [8:0] egr,
                           input logic clr, input logic push, input exp_t e);
    int budget = 0;
    s_axis_if.valid             = 1'b1;
    s_axis_if.keep              = keep;
    s_axis_if.last              = last;
    s_axis_if.user_valid        = uv;
    s_axis_if.user_size         = usize;
    s_axis_if.user_ingress_port = ing;
    s_axis_if.user_egress_port  = egr;
    s_axis_if.data              = {16{$urandom()}};
    stats_clr                   = clr;
    while (s_axis_if.ready !== 1'b1 && budget < 200) begin
      @(negedge aclk);
      budget++;
    end
    if (budget >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=%b expected 1 within 200 cycles", s_axis_if.ready);
    end else if (push) begin
      sb_q.push_back(e);
    end
    @(negedge aclk);
    stats_clr = 1'b0;
  endtask

  task automatic idle();
    s_axis_if.valid = 1'b0;
    @(negedge aclk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"},      64'(s_axis_if.ready), 64'd0);
    chk({tag, "_pkt_done"},   64'(pkt_done),   64'd0);
    chk({tag, "_last_size"},  64'(last_size),  64'd0);
    chk({tag, "_pkt_count"},  64'(pkt_count),  64'd0);
    chk({tag, "_byte_count"}, 64'(byte_count), 64'd0);
    chk({tag, "_err_count"},  64'(err_count),  64'd0);
    chk({tag, "_err_flags"},  64'(err_flags),  64'd0);
  endtask

  // Scoreboard: every pkt_done pops one expected completion.
  always @(posedge aclk) begin : monitor
    exp_t e;
    #1;
    if (s_axis_if.ready !== 1'b1 && areset === 1'b0) ready_low++;
    if (pkt_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pkt_done: got pkt_done=1 expected no completion");
      end else begin
        e = sb_q.pop_front();
        chk("last_size",    64'(last_size),    64'(e.size));
        chk("last_ingress", 64'(last_ingress), 64'(e.ing));
        chk("last_egress",  64'(last_egress),  64'(e.egr));
        chk("pkt_count",    64'(pkt_count),    e.pkt);
        chk("byte_count",   64'(byte_count),   e.bytes);
        chk("err_count",    64'(err_count),    e.errc);
        chk("err_flags",    64'(err_flags),    64'(e.flags));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    exp_t e;
    exp_t none;
    none = '{default: '0};
    s_axis_if.valid = 1'b0; s_axis_if.keep = '0; s_axis_if.last = 1'b0;
    s_axis_if.user_valid = 1'b0; s_axis_if.user_size = '0; s_axis_if.data = '0;
    s_axis_if.user_ingress_port = '0; s_axis_if.user_egress_port = '0;

    // Reset state, and ready rising only after the first clock past release.
    repeat (2) @(negedge aclk);
    chk_zero("reset");
    areset = 1'b0;
    #1 chk("ready_at_release", 64'(s_axis_if.ready), 64'd0);
    @(negedge aclk);
    chk("ready_after_release", 64'(s_axis_if.ready), 64'd1);

    vt.push_back(mk(64'hFFFF, 1, 1, 16,  3, 7, 0, 16,  1, 16,  0, 4'b0000));
    vt.push_back(mk(F,        0, 0, 0,   0, 0, 0, 0,   0, 0,   0, 4'b0000));
    vt.push_back(mk(F,        0, 0, 0,   0, 0, 0, 0,   0, 0,   0, 4'b0000));
    vt.push_back(mk(64'hFF,   1, 1, 136, 5, 9, 0, 136, 2, 152, 0, 4'b0000));
    vt.push_back(mk(F,        0, 0, 0,   0, 0, 0, 0,   0, 0,   0, 4'b0000));
    vt.push_back(mk(F,        0, 0, 0,   0, 0, 0, 0,   0, 0,   0, 4'b0000));
    vt.push_back(mk(64'hFF,   1, 1, 140, 1, 2, 0, 136, 3, 288, 1, 4'b0010));
    vt.push_back(mk(64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    vt.push_back(mk(64'hF,    1, 1, 67,  4, 4, 0, 67,  4, 355, 2, 4'b0011));
    vt.push_back(mk(64'h5,    1, 1, 2,   6, 6, 0, 2,   5, 357, 3, 4'b0011));
    vt.push_back(mk(F,        0, 1, 0,   0, 0, 0, 0,   0, 0,   0, 4'b0000));
    vt.push_back(mk(64'h1,    1, 1, 65,  7, 8, 0, 65,  6, 422, 4, 4'b0111));
    vt.push_back(mk(64'h0,    1, 1, 0,   1, 1, 0, 0,   7, 422, 5, 4'b1111));
    vt.push_back(mk(64'hFF,   1, 0, 0,   2, 3, 0, 8,   8, 430, 6, 4'b1111));
    vt.push_back(mk(F,        1, 1, 64, 10, 11, 1, 64, 0, 0,   0, 4'b0000));
    vt.push_back(mk(64'hFFFF_FFFF, 1, 1, 32, 12, 13, 0, 32, 1, 32, 0, 4'b0000));
    vt.push_back(mk(F,        0, 0, 0,   0, 0, 1, 0,   0, 0,   0, 4'b0000));
    vt.push_back(mk(64'hFFFF, 1, 1, 80, 14, 15, 0, 80,  1, 80,  0, 4'b0000));

    foreach (vt[i]) begin
      e.size = vt[i].e_size; e.ing = vt[i].ing; e.egr = vt[i].egr; e.pkt = vt[i].e_pkt;
      e.bytes = vt[i].e_bytes; e.errc = vt[i].e_errc; e.flags = vt[i].e_flags;
      send_beat(vt[i].keep, vt[i].last, vt[i].uv, vt[i].usize, vt[i].ing, vt[i].egr,
                vt[i].clr, vt[i].last, e);
    end
    idle();

    // Accumulator reaching exactly 65535, then overflowing into saturation.
    for (int b = 0; b < 1023; b++) send_beat(F, 0, 0, 0, 0, 0, 0, 0, none);
    e = '{size: 16'hFFFF, ing: 20, egr: 21, pkt: 2, bytes: 65615, errc: 0, flags: 4'b0000};
    send_beat(64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 16'hFFFF, 20, 21, 0, 1, e);
    for (int b = 0; b < 1023; b++) send_beat(F, 0, 0, 0, 0, 0, 0, 0, none);
    e = '{size: 16'hFFFF, ing: 22, egr: 23, pkt: 3, bytes: 131150, errc: 1, flags: 4'b0010};
    send_beat(F, 1, 1, 16'hFFFF, 22, 23, 0, 1, e);

    // Reset in the middle of a two-beat packet, then a clean packet.
    send_beat(F, 0, 0, 0, 0, 0, 0, 0, none);
    s_axis_if.valid = 1'b0;
    areset = 1'b1;
    #1 chk_zero("midreset");
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    e = '{size: 64, ing: 30, egr: 31, pkt: 1, bytes: 64, errc: 0, flags: 4'b0000};
    send_beat(F, 1, 1, 64, 30, 31, 0, 1, e);
    idle();

`ifdef VNP4_SINK_BACKPRESSURE_EN
    begin : backpressure
      int unsigned nb, n, total, low_before;
      logic [63:0] keep, m_pkt, m_bytes, m_errc;
      logic [3:0]  m_flags;
      logic        bad;

      low_before = ready_low;
      repeat (50) @(negedge aclk);
      chk("throttle_dis_ready_low_cycles", 64'(ready_low - low_before), 64'd0);

      stats_clr = 1'b1;
      @(negedge aclk);
      stats_clr = 1'b0;
      m_pkt = 0; m_bytes = 0; m_errc = 0; m_flags = '0;
      throttle_dis = 1'b0;
      low_before = ready_low;

      for (int p = 0; p < 1000; p++) begin
        nb    = $urandom_range(1, 3);
        n     = $urandom_range(1, 64);
        keep  = (n == 64) ? F : ((64'd1 << n) - 64'd1);
        total = 64 * (nb - 1) + n;
        bad   = ($urandom_range(0, 9) == 0);
        for (int unsigned b = 1; b < nb; b++) send_beat(F, 0, 0, 0, 0, 0, 0, 0, none);
        m_pkt   = m_pkt + 1;
        m_bytes = m_bytes + 64'(total);
        if (bad) begin
          m_errc  = m_errc + 1;
          m_flags = m_flags | 4'b0010;
        end
        e = '{size: 16'(total), ing: 9'(p), egr: 9'(p + 1), pkt: m_pkt, bytes: m_bytes,
              errc: m_errc, flags: m_flags};
        send_beat(keep, 1, 1, 16'(bad ? total + 1 : total), 9'(p), 9'(p + 1), 0, 1, e);
        if ($urandom_range(0, 3) == 0) idle();
      end
      idle();
      chk("backpressure_ready_seen_low", 64'(ready_low > low_before), 64'd1);
      throttle_dis = 1'b1;
    end
`endif

    repeat (5) @(negedge aclk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
